pat_field_buffer: RTL and testbench

- Pattern-buffer responder on the far end of the processor's field interface.
- Holds 2^bufp_width buffers of 2^fieldp_width fields, each buffer_width bits wide.
- Serves field reads addressed by bufp/fieldp and accepts field writes at fieldwp.
- Buffers are filled from an inbound valid/ready stream and drained, in order, to an outbound valid/ready stream once the processor releases them.

---
 rtl/pat_buf_pkg.sv | 29 ++
 rtl/pat_buf_stream_port.sv | 64 ++++++
 rtl/pat_field_buffer.sv | 131 +++++++++++++
 tb/tb_pat_field_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_buf_pkg.sv
// Shared definitions for the pattern field buffer: buffer lifecycle states,
// stream port direction and buffer geometry helpers.
package pat_buf_pkg;

    localparam int DEF_BUFP_WIDTH   = 3;
    localparam int DEF_FIELDP_WIDTH = 5;
    localparam int DEF_BUFFER_WIDTH = 8;

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_DONE    = 2'd3
    } buf_state_e;

    typedef enum logic {
        PORT_FILL  = 1'b0,
        PORT_DRAIN = 1'b1
    } port_dir_e;

    function automatic int nbuf(input int bufp_width);
        return 1 << bufp_width;
    endfunction

    function automatic int nfield(input int fieldp_width);
        return 1 << fieldp_width;
    endfunction

endpackage

// File: rtl/pat_buf_stream_port.sv
// Buffer/field walker with valid-ready control, shared by the fill side
// (drives ready) and the drain side (drives valid).
module pat_buf_stream_port
    import pat_buf_pkg::*;
#(
    parameter port_dir_e DIR   = PORT_FILL,
    parameter int        PTR_W = DEF_BUFP_WIDTH,
    parameter int        IDX_W = DEF_FIELDP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_ok,
    input  logic             peer,
    output logic [PTR_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             hs,
    output logic             arm,
    output logic             last
);

    logic active;
    logic xfer;

    assign xfer = hs && peer;
    assign last = xfer && (idx == {IDX_W{1'b1}});

    // arm marks the edge on which hs rises: fill opens ready as soon as the buffer
    // is claimed, drain reloads its output register once per field after each handshake.
    always_comb begin
        arm = 1'b0;
        if (DIR == PORT_FILL) begin
            arm = !active && start_ok;
        end else begin
            arm = active && !hs;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr    <= '0;
            idx    <= '0;
            hs     <= 1'b0;
            active <= 1'b0;
        end else begin
            if (!active && start_ok) begin
                active <= 1'b1;
            end
            if (arm) begin
                hs <= 1'b1;
            end
            if (xfer) begin
                idx <= idx + 1'b1;
                if (last) begin
                    active <= 1'b0;
                    hs     <= 1'b0;
                    ptr    <= ptr + 1'b1;
                end else if (DIR == PORT_DRAIN) begin
                    hs <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pat_field_buffer.sv
// Pattern buffer responder: buffers fill from an inbound stream, are edited and
// released by the processor, then drain in index order to an outbound stream.
module pat_field_buffer
    import pat_buf_pkg::*;
#(
    parameter int bufp_width   = DEF_BUFP_WIDTH,
    parameter int fieldp_width = DEF_FIELDP_WIDTH,
    parameter int buffer_width = DEF_BUFFER_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bufp_width-1:0]   bufp,
    input  logic [fieldp_width-1:0] fieldp,
    output logic [buffer_width-1:0] field_in,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    field_we,
    input  logic                    buf_done,
    output logic                    buf_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [buffer_width-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [buffer_width-1:0] out_data
);

    localparam int NBUF   = nbuf(bufp_width);
    localparam int NFIELD = nfield(fieldp_width);

    buf_state_e              state [NBUF];
    logic [buffer_width-1:0] mem   [NBUF][NFIELD];

    logic [bufp_width-1:0]   fill_ptr;
    logic [bufp_width-1:0]   drain_ptr;
    logic [fieldp_width-1:0] fill_idx;
    logic [fieldp_width-1:0] drain_idx;
    logic                    fill_arm;
    logic                    fill_last;
    logic                    drain_arm;
    logic                    drain_last;
    logic                    fill_start_ok;
    logic                    drain_start_ok;
    logic                    fill_we;
    logic                    proc_we;
    logic                    proc_done;

    assign fill_start_ok  = (state[fill_ptr] == BUF_FREE);
    assign drain_start_ok = (state[drain_ptr] == BUF_DONE);
    assign fill_we        = in_valid && in_ready;
    assign buf_ready      = (state[bufp] == BUF_FULL);
    assign proc_we        = field_we && buf_ready;
    assign proc_done      = buf_done && buf_ready;
    assign field_in       = mem[bufp][fieldp];

    pat_buf_stream_port #(
        .DIR   (PORT_FILL),
        .PTR_W (bufp_width),
        .IDX_W (fieldp_width)
    ) u_fill (
        .clk      (clk),
        .reset    (reset),
        .start_ok (fill_start_ok),
        .peer     (in_valid),
        .ptr      (fill_ptr),
        .idx      (fill_idx),
        .hs       (in_ready),
        .arm      (fill_arm),
        .last     (fill_last)
    );

    pat_buf_stream_port #(
        .DIR   (PORT_DRAIN),
        .PTR_W (bufp_width),
        .IDX_W (fieldp_width)
    ) u_drain (
        .clk      (clk),
        .reset    (reset),
        .start_ok (drain_start_ok),
        .peer     (out_ready),
        .ptr      (drain_ptr),
        .idx      (drain_idx),
        .hs       (out_valid),
        .arm      (drain_arm),
        .last     (drain_last)
    );

    // Each transition requires a distinct source state, so the four updates can
    // never target the same buffer in one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NBUF; i++) begin
                state[i] <= BUF_FREE;
            end
        end else begin
            if (fill_arm) begin
                state[fill_ptr] <= BUF_FILLING;
            end
            if (fill_last) begin
                state[fill_ptr] <= BUF_FULL;
            end
            if (proc_done) begin
                state[bufp] <= BUF_DONE;
            end
            if (drain_last) begin
                state[drain_ptr] <= BUF_FREE;
            end
        end
    end

    // Storage is never cleared; writes are blocked only while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (fill_we) begin
                mem[fill_ptr][fill_idx] <= in_data;
            end
            if (proc_we) begin
                mem[bufp][fieldwp] <= field_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data <= '0;
        end else if (drain_arm) begin
            out_data <= mem[drain_ptr][drain_idx];
        end
    end

endmodule

// File: tb/tb_pat_field_buffer.sv
// Self-checking bench for pat_field_buffer: random and ramp streams checked
// against a buffer-level model of fill, processor edits and in-order drain.
module tb_pat_field_buffer;

    localparam int BPW    = 3;
    localparam int FPW    = 5;
    localparam int DW     = 8;
    localparam int NBUF   = 1 << BPW;
    localparam int NFIELD = 1 << FPW;

    localparam int M_FREE    = 0;
    localparam int M_FILLING = 1;
    localparam int M_FULL    = 2;
    localparam int M_DONE    = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [BPW-1:0] bufp;
    logic [FPW-1:0] fieldp;
    logic [DW-1:0]  field_in;
    logic [FPW-1:0] fieldwp;
    logic [DW-1:0]  field_out;
    logic           field_we;
    logic           buf_done;
    logic           buf_ready;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [NBUF][NFIELD];
    int            mstate [NBUF];
    int            fptr;
    int            fidx;
    int            dptr;

    pat_field_buffer #(
        .bufp_width   (BPW),
        .fieldp_width (FPW),
        .buffer_width (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bufp      (bufp),
        .fieldp    (fieldp),
        .field_in  (field_in),
        .fieldwp   (fieldwp),
        .field_out (field_out),
        .field_we  (field_we),
        .buf_done  (buf_done),
        .buf_ready (buf_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int b, input int fp, input int wp, input logic [DW-1:0] d,
                                 input logic we, input logic done);
        bufp      = BPW'(b);
        fieldp    = FPW'(fp);
        fieldwp   = FPW'(wp);
        field_out = d;
        field_we  = we;
        buf_done  = done;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NBUF; i++) mstate[i] = M_FREE;
        fptr = 0;
        fidx = 0;
        dptr = 0;
    endtask

    task automatic pushWord(input logic [DW-1:0] d);
        int waitc;
        bit acc;
        waitc    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && waitc < 100) begin
            tick();
            waitc++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 1);
        acc = (in_ready === 1'b1);
        tick();
        if (acc) begin
            model_mem[fptr][fidx] = d;
            if (fidx == NFIELD - 1) begin
                mstate[fptr] = M_FULL;
                fidx = 0;
                fptr = (fptr + 1) % NBUF;
            end else begin
                mstate[fptr] = M_FILLING;
                fidx++;
            end
        end
    endtask

    task automatic fillBuffer(input bit ramp);
        for (int i = 0; i < NFIELD; i++) begin
            pushWord(ramp ? DW'(i) : DW'($urandom_range(0, 255)));
        end
        in_valid = 1'b0;
    endtask

    task automatic procPulse(input int b, input int wp, input logic [DW-1:0] d,
                             input logic we, input logic done);
        applyStimulus(b, 0, wp, d, we, done);
        if (mstate[b] == M_FULL) begin
            if (we) model_mem[b][wp] = d;
            if (done) mstate[b] = M_DONE;
        end
        tick();
        field_we = 1'b0;
        buf_done = 1'b0;
    endtask

    task automatic popBuffer(input bit toggle);
        int waitc;
        for (int i = 0; i < NFIELD; i++) begin
            waitc = 0;
            while (out_valid !== 1'b1 && waitc < 100) begin
                tick();
                waitc++;
            end
            checkOutput("drain_valid", 32'(out_valid), 1);
            checkOutput("drain_data", 32'(out_data), 32'(model_mem[dptr][i]));
            if (toggle && (i % 2 == 1)) begin
                out_ready = 1'b0;
                tick();
                checkOutput("stall_valid", 32'(out_valid), 1);
                checkOutput("stall_data", 32'(out_data), 32'(model_mem[dptr][i]));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        mstate[dptr] = M_FREE;
        dptr = (dptr + 1) % NBUF;
        checkOutput("drain_end_valid", 32'(out_valid), 0);
    endtask

    task automatic checkBufReady(input int b);
        applyStimulus(b, 0, 0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("buf_ready", 32'(buf_ready), (mstate[b] == M_FULL) ? 1 : 0);
    endtask

    initial begin
        int wsel;
        int waitc;
        logic [DW-1:0] wdat;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        applyStimulus(0, 0, 0, '0, 1'b0, 1'b0);
        modelReset();
        tick();
        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_out_data", 32'(out_data), 0);
        reset = 1'b1;

        $display("[TB] ramp fill of buffer 0");
        fillBuffer(1'b1);
        applyStimulus(0, 5, 0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("field_in_5", 32'(field_in), 32'h05);
        checkOutput("buf_ready_0", 32'(buf_ready), 1);
        for (int k = 0; k < 4; k++) begin
            wsel = $urandom_range(0, NFIELD - 1);
            applyStimulus(0, wsel, 0, '0, 1'b0, 1'b0);
            #1;
            checkOutput("field_in_rand", 32'(field_in), 32'(model_mem[0][wsel]));
        end

        $display("[TB] edit and release buffer 0");
        procPulse(0, 3, 8'hAA, 1'b1, 1'b0);
        applyStimulus(0, 3, 0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("field_in_aa", 32'(field_in), 32'hAA);
        procPulse(0, 0, '0, 1'b0, 1'b1);
        popBuffer(1'b0);
        checkBufReady(0);

        $display("[TB] fill all buffers for backpressure");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        modelReset();
        for (int b = 0; b < NBUF; b++) fillBuffer(1'b0);
        tick();
        tick();
        tick();
        checkOutput("backpressure", 32'(in_ready), 0);
        for (int b = 0; b < NBUF; b++) checkBufReady(b);

        $display("[TB] out-of-order release waits for drain pointer");
        procPulse(2, 0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("done_waits", 32'(out_valid), 0);
        procPulse(0, 0, '0, 1'b0, 1'b1);
        popBuffer(1'b1);
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        checkOutput("in_ready_returns", 32'(in_ready), 1);

        wsel = $urandom_range(0, NFIELD - 1);
        wdat = DW'($urandom_range(0, 255));
        procPulse(1, wsel, wdat, 1'b1, 1'b1);
        popBuffer(1'b0);
        popBuffer(1'b1);

        $display("[TB] writes and release on a free buffer");
        wsel = $urandom_range(0, NFIELD - 1);
        procPulse(1, wsel, 8'h5A, 1'b1, 1'b1);
        checkBufReady(1);
        applyStimulus(1, wsel, 0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("free_mem_unchanged", 32'(field_in), 32'(model_mem[1][wsel]));
        for (int k = 0; k < 5; k++) tick();
        checkOutput("free_no_drain", 32'(out_valid), 0);

        $display("[TB] reset in the middle of a fill");
        for (int k = 0; k < 10; k++) pushWord(DW'($urandom_range(0, 255)));
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        checkOutput("midreset_in_ready", 32'(in_ready), 0);
        checkOutput("midreset_out_valid", 32'(out_valid), 0);
        modelReset();
        for (int b = 0; b < NBUF; b++) checkBufReady(b);
        reset = 1'b1;
        fillBuffer(1'b0);
        checkBufReady(0);
        checkBufReady(1);
        applyStimulus(0, 0, 0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("restart_field0", 32'(field_in), 32'(model_mem[0][0]));
        procPulse(0, 0, '0, 1'b0, 1'b1);
        popBuffer(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
